mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Initiator-side controller for the single-port synchronous data memory (`Memory`). It accepts load/store requests from the pipeline's memory stage over a valid/ready handshake. It converts byte addresses to word indices, rejects misaligned and out-of-range accesses, and drives the memory's `wen`/`ren`/`adr`/`din` strobes. It captures the one-cycle-latency read data and returns a response over a second valid/ready handshake, with saturating access counters for debug.

## Interface

- `depth`, 128, number of words in the attached memory; word index must be < depth
- `bits`, 32, request byte-address width and memory address width
- `width`, 32, data width

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  bits  byte address
- `req_wdata`  in  width  store data
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  consumer accepts response
- `resp_rdata`  out  width  load data; 0 for stores and errors
- `resp_err`  out  1  access rejected (misaligned or out of range)
- `mem_wen`  out  1  to memory `wen`
- `mem_ren`  out  1  to memory `ren`
- `mem_adr`  out  bits  to memory `adr`, word index
- `mem_din`  out  width  to memory `din`
- `mem_dout`  in  width  from memory `dout`
- `rd_count`, `wr_count`, `err_count`  out  16 each  saturating counts of completed loads, stores and errors

## Operation

- Word index = `req_addr >> 2`, zero-extended to `bits`.
- Misaligned: `req_addr[1:0] != 0`. Out of range: word index >= `depth`. Either condition makes the request an error.
- States:
  - IDLE: `req_ready`=1. On `req_valid`, register `we`, the word index and `wdata`. Go to ISSUE if legal, or to RESP with err=1 if not.
  - ISSUE: exactly one cycle. Drive `mem_ren`=!we or `mem_wen`=we, with `mem_adr`/`mem_din` from the registers. Stores go to RESP and loads go to WAIT.
  - WAIT: one cycle. `mem_dout` is valid and is captured into the `resp_rdata` register at the end of the cycle. Go to RESP.
  - RESP: `resp_valid`=1. `resp_rdata`, `resp_err` and `mem_*` are held stable. On `resp_ready`, go to IDLE and increment the matching counter.
- `req_ready`=0 in every state except IDLE. There is no request pipelining: one outstanding access.
- `mem_wen`/`mem_ren` are 0 in every state except ISSUE and are never both 1. `mem_adr`/`mem_din` hold their last values outside ISSUE.
- Error requests never assert `mem_wen` or `mem_ren`.
- Counters saturate at 16'hFFFF and do not wrap.

## Timing

- Cycle 0 is the IDLE cycle in which the handshake happens.
- Load: ISSUE in cycle 1, WAIT in cycle 2, `resp_valid` from cycle 3 (3-cycle latency).
- Store: ISSUE in cycle 1, `resp_valid` from cycle 2.
- Error: `resp_valid` from cycle 1.
- Response handshake: the transfer occurs in the cycle with `resp_valid && resp_ready`. The next cycle is IDLE with `req_ready`=1. The minimum load-to-load spacing is therefore 4 cycles.
- `resp_ready` may be held high in advance; this does not shorten the latency.
- Reset value of every output: `req_ready`=0 while `rst`=1, and 1 in the first cycle after release. All other outputs, including the counters, are 0.
- Reset mid-operation: state returns to IDLE immediately and the strobes drop asynchronously. No response is produced and the counters clear. If the reset occurs during ISSUE before the clock edge, the store is not performed.
- `req_*` inputs are sampled only in the IDLE handshake cycle; changes at other times are ignored.

## Test plan

- Store 0xDEADBEEF to 0x10, then load 0x10:
  - Store: one cycle of `mem_wen`=1 with `mem_adr`=4; `resp_valid` 2 cycles after the handshake with err=0.
  - Load: `resp_rdata`=0xDEADBEEF 3 cycles after the handshake; `wr_count`=1, `rd_count`=1.
- Load at 0x13 -> `resp_err`=1 one cycle after the handshake, `resp_rdata`=0, `mem_ren`/`mem_wen` never asserted, `err_count`=1.
- Store at 0x200 (word 128, depth 128) -> error response; a subsequent load at 0x1FC (word 127) succeeds.
- Load with `resp_ready` low for 5 cycles -> `resp_valid`, `resp_rdata` and `resp_err` stable throughout, `req_ready`=0, no further memory strobes; the response completes on the cycle `resp_ready` rises.
- Assert `rst` during WAIT of a load -> all outputs 0 immediately, no response after release; `req_ready`=1 in the first post-reset cycle.
- Back-to-back stores at addresses 0, 4, …, 508 with `resp_ready` held high -> each store takes 3 cycles handshake-to-handshake; addresses ≥512 all error; final `wr_count`=128, `err_count` = number of out-of-range stores.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator-side controller for a single-port synchronous
// data memory. Takes one load/store request at a time, rejects misaligned
// and out-of-range accesses, drives the memory strobes for one cycle and
// returns a response. Keeps saturating counts of completed accesses.
//
// Handshakes: a transfer happens on a rising clock edge where valid && ready
// are both high. The producer holds valid and its payload until that edge.
// req_ready is high only in IDLE. resp_valid is high only in RESP, and the
// response payload does not change until the transfer happens.
module mem_access_ctrl #(
    parameter int depth = 128,
    parameter int bits  = 32,
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [bits-1:0]  req_addr,
    input  logic [width-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [width-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_wen,
    output logic             mem_ren,
    output logic [bits-1:0]  mem_adr,
    output logic [width-1:0] mem_din,
    input  logic [width-1:0] mem_dout,
    output logic [15:0]      rd_count,
    output logic [15:0]      wr_count,
    output logic [15:0]      err_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [bits-1:0] depth_w = bits'(depth);

    state_t           state;
    state_t           state_next;

    logic [bits-1:0]  word_idx;
    logic             req_bad;
    logic             req_fire;
    logic             resp_fire;

    logic             we_q;
    logic [bits-1:0]  idx_q;
    logic [width-1:0] wdata_q;
    logic             err_q;
    logic [width-1:0] rdata_q;
    logic [bits-1:0]  adr_hold;
    logic [width-1:0] din_hold;

    logic [15:0]      rd_cnt;
    logic [15:0]      wr_cnt;
    logic [15:0]      err_cnt;

    // Byte address to word index; the low two bits must be zero.
    assign word_idx  = {2'b00, req_addr[bits-1:2]};
    assign req_bad   = (req_addr[1:0] != 2'b00) || (word_idx >= depth_w);
    assign req_fire  = (state == S_IDLE) && req_valid;
    assign resp_fire = (state == S_RESP) && resp_ready;

    // req_ready is masked by rst so it reads 0 while reset is held.
    assign req_ready  = (state == S_IDLE) && !rst;
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Memory address/data follow the request registers during ISSUE and
    // otherwise hold whatever was last presented to the memory.
    assign mem_adr = (state == S_ISSUE) ? idx_q   : adr_hold;
    assign mem_din = (state == S_ISSUE) ? wdata_q : din_hold;

    assign rd_count  = rd_cnt;
    assign wr_count  = wr_cnt;
    assign err_count = err_cnt;

    // State register; reset returns to IDLE at once so strobes drop async.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the one-cycle memory strobes.
    always_comb begin
        state_next = state;
        mem_wen    = 1'b0;
        mem_ren    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_next = req_bad ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_wen    = we_q;
                mem_ren    = !we_q;
                state_next = we_q ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                state_next = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Request capture, memory address/data hold and read-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            adr_hold <= '0;
            din_hold <= '0;
        end else begin
            if (req_fire) begin
                we_q    <= req_we;
                idx_q   <= word_idx;
                wdata_q <= req_wdata;
                err_q   <= req_bad;
                rdata_q <= '0;
            end
            if (state == S_ISSUE) begin
                adr_hold <= idx_q;
                din_hold <= wdata_q;
            end
            if (state == S_WAIT) begin
                rdata_q <= mem_dout;
            end
        end
    end

    // Saturating completion counters, stepped on the response transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else if (resp_fire) begin
            if (err_q) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end else if (we_q) begin
                if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
            end else begin
                if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed scenarios followed by random
// accesses, checked against a word-array reference and latency rules.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_adr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic [15:0] err_count;

    int checks;
    int failures;
    int cyc = 0;

    // Reference state: expected memory contents, counters, held address.
    logic [31:0] ref_mem [128];
    int          exp_rd;
    int          exp_wr;
    int          exp_err;
    logic [31:0] last_adr;

    mem_access_ctrl #(.depth(128), .bits(32), .width(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_adr    (mem_adr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .err_count  (err_count)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Attached single-port memory, one-cycle read latency, not reset.
    logic [31:0] mem [128] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_wen && mem_adr < 32'd128) mem[mem_adr[6:0]] <= mem_din;
        if (mem_ren) mem_dout <= (mem_adr < 32'd128) ? mem[mem_adr[6:0]] : 32'hBAD0BAD0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        check({tag, "_mem_wen"}, 32'(mem_wen), 32'd0);
        check({tag, "_mem_ren"}, 32'(mem_ren), 32'd0);
        check({tag, "_mem_adr"}, mem_adr, 32'd0);
        check({tag, "_mem_din"}, mem_din, 32'd0);
        check({tag, "_rd_count"}, 32'(rd_count), 32'd0);
        check({tag, "_wr_count"}, 32'(wr_count), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    task automatic clear_ref_counters();
        exp_rd   = 0;
        exp_wr   = 0;
        exp_err  = 0;
        last_adr = 32'd0;
    endtask

    // Full access: handshake, latency/strobe checks, optional stall of
    // resp_ready, response transfer, then counter checks back in IDLE.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int hold, input bit pre_ready, output int hs_cyc);
        logic [31:0] idx;
        logic [31:0] exp_data;
        bit          err;
        int          lat;
        int          wen_n;
        int          ren_n;
        idx      = addr >> 2;
        err      = (addr[1:0] != 2'b00) || (idx >= 32'd128);
        lat      = err ? 1 : (we ? 2 : 3);
        exp_data = (err || we) ? 32'd0 : ref_mem[idx[6:0]];
        for (int t = 0; t < 20 && req_ready !== 1'b1; t++) @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = pre_ready;
        hs_cyc     = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        wen_n = 0;
        ren_n = 0;
        for (int k = 1; k < lat; k++) begin
            check("busy_resp_valid", 32'(resp_valid), 32'd0);
            check("busy_req_ready", 32'(req_ready), 32'd0);
            if (mem_wen === 1'b1) begin
                wen_n++;
                check("store_adr", mem_adr, idx);
                check("store_din", mem_din, wdata);
            end
            if (mem_ren === 1'b1) begin
                ren_n++;
                check("load_adr", mem_adr, idx);
            end
            @(negedge clk);
        end
        if (!err) last_adr = idx;
        check("wen_cycles", 32'(wen_n), (!err && we) ? 32'd1 : 32'd0);
        check("ren_cycles", 32'(ren_n), (!err && !we) ? 32'd1 : 32'd0);
        for (int h = 0; h <= hold; h++) begin
            if (h == hold) resp_ready = 1'b1;
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("resp_err", 32'(resp_err), 32'(err));
            check("resp_rdata", resp_rdata, exp_data);
            check("resp_req_ready", 32'(req_ready), 32'd0);
            check("resp_strobes", {30'd0, mem_wen, mem_ren}, 32'd0);
            check("resp_adr_hold", mem_adr, last_adr);
            if (h == hold) break;
            resp_ready = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        if (err) begin
            if (exp_err < 65535) exp_err++;
        end else if (we) begin
            ref_mem[idx[6:0]] = wdata;
            if (exp_wr < 65535) exp_wr++;
        end else begin
            if (exp_rd < 65535) exp_rd++;
        end
        check("after_req_ready", 32'(req_ready), 32'd1);
        check("after_resp_valid", 32'(resp_valid), 32'd0);
        check("rd_count", 32'(rd_count), 32'(exp_rd));
        check("wr_count", 32'(wr_count), 32'(exp_wr));
        check("err_count", 32'(err_count), 32'(exp_err));
    endtask

    // Reset with no access in flight.
    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero(tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, "_req_ready_post"}, 32'(req_ready), 32'd1);
        clear_ref_counters();
    endtask

    // Access interrupted by reset in cycle at_cyc after the handshake.
    task automatic reset_mid(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int at_cyc);
        for (int t = 0; t < 20 && req_ready !== 1'b1; t++) @(negedge clk);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = 1'b1;
        for (int k = 0; k < at_cyc; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        if (at_cyc == 1) begin
            check({tag, "_strobe_before"}, {30'd0, mem_wen, mem_ren}, we ? 32'd2 : 32'd1);
        end
        rst = 1'b1;
        #1;
        check_outputs_zero(tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, "_req_ready_post"}, 32'(req_ready), 32'd1);
        clear_ref_counters();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check({tag, "_no_resp"}, 32'(resp_valid), 32'd0);
            check({tag, "_no_strobe"}, {30'd0, mem_wen, mem_ren}, 32'd0);
        end
    endtask

    initial begin
        int          hs;
        int          prev_hs;
        bit          prev_err;
        logic [31:0] a;
        logic [31:0] d;
        int          kind;
        checks    = 0;
        failures  = 0;
        foreach (ref_mem[i]) ref_mem[i] = 32'd0;
        clear_ref_counters();
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;

        // Power-on reset values.
        #12;
        check_outputs_zero("por");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("por_req_ready_post", 32'(req_ready), 32'd1);

        // Store then load the same word.
        do_access(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, hs);
        do_access(1'b0, 32'h10, 32'h0, 0, 1'b0, hs);
        check("plan_wr_count", 32'(wr_count), 32'd1);
        check("plan_rd_count", 32'(rd_count), 32'd1);

        // Misaligned load, then out-of-range store, then last legal word.
        do_access(1'b0, 32'h13, 32'h0, 0, 1'b1, hs);
        check("plan_err_count", 32'(err_count), 32'd1);
        do_access(1'b1, 32'h200, 32'h12345678, 0, 1'b1, hs);
        do_access(1'b1, 32'h1FC, 32'hCAFEF00D, 0, 1'b1, hs);
        do_access(1'b0, 32'h1FC, 32'h0, 0, 1'b0, hs);

        // Load with the consumer stalling for five cycles.
        do_access(1'b0, 32'h10, 32'h0, 5, 1'b0, hs);

        // Reset during WAIT of a load, and during ISSUE of a store.
        reset_mid("rst_wait", 1'b0, 32'h10, 32'h0, 2);
        reset_mid("rst_issue", 1'b1, 32'h10, 32'h55555555, 1);
        do_access(1'b0, 32'h10, 32'h0, 0, 1'b0, hs);

        // Back-to-back stores across the whole range and past its end.
        apply_reset("sweep");
        prev_hs  = 0;
        prev_err = 1'b0;
        for (int i = 0; i <= 135; i++) begin
            a = 32'(i) * 32'd4;
            d = $urandom;
            do_access(1'b1, a, d, 0, 1'b1, hs);
            if (i > 0) check("sweep_gap", 32'(hs - prev_hs), prev_err ? 32'd2 : 32'd3);
            prev_hs  = hs;
            prev_err = (a >= 32'd512);
        end
        check("sweep_wr_total", 32'(wr_count), 32'd128);
        check("sweep_err_total", 32'(err_count), 32'd8);

        // Random mix of legal, misaligned and out-of-range accesses.
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0, 1:    a = 32'($urandom_range(0, 127)) * 32'd4;
                2:       a = 32'($urandom_range(0, 127)) * 32'd4 + 32'($urandom_range(1, 3));
                default: a = 32'($urandom_range(128, 4000)) * 32'd4;
            endcase
            do_access(1'($urandom), a, $urandom, int'($urandom_range(0, 3)), 1'($urandom), hs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
